// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter that shares one iterative divider among
// NREQ requesters. One operation is outstanding at a time. Divide-by-zero is
// answered locally, and a watchdog turns a missing div_done into an error
// response.
module div_arbiter #(
  parameter int NREQ = 4,
  parameter int TMO  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_n,
  input  logic [16*NREQ-1:0]   req_d,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [7:0]           rsp_q,
  output logic [15:0]          rsp_r,
  output logic                 rsp_err,
  output logic                 div_start,
  output logic [15:0]          div_n,
  output logic [15:0]          div_d,
  input  logic [7:0]           div_q,
  input  logic [15:0]          div_r,
  input  logic                 div_done,
  output logic                 busy
);

  localparam int IW = $clog2(NREQ);
  localparam int WW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, owner, grant_idx;
  logic            grant_vld;
  logic [15:0]     cap_n, cap_d, cap_r;
  logic [7:0]      cap_q;
  logic            cap_err;
  logic [WW-1:0]   wdog;
  logic            done_ok, tmo_hit;

  // wdog is 0 only in the first WAIT cycle, so a done still high from the
  // previous operation is ignored there.
  assign done_ok = div_done && (wdog != '0);
  assign tmo_hit = (wdog == WW'(TMO - 1));

  // Rotating-priority search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_vld && req_valid[IW'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake/strobe outputs.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    div_start = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req_ready[grant_idx] = 1'b1;
          state_nxt            = ISSUE;
        end
      end
      ISSUE: begin
        div_start = (cap_d != '0);
        state_nxt = (cap_d != '0) ? WAIT : RESP;
      end
      WAIT: begin
        if (done_ok || tmo_hit) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[owner] = 1'b1;
        if (rsp_ready[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/result capture, watchdog and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr  <= '0;
      owner   <= '0;
      cap_n   <= '0;
      cap_d   <= '0;
      cap_q   <= '0;
      cap_r   <= '0;
      cap_err <= 1'b0;
      wdog    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner <= grant_idx;
            cap_n <= req_n[{grant_idx, 4'b0} +: 16];
            cap_d <= req_d[{grant_idx, 4'b0} +: 16];
          end
        end
        ISSUE: begin
          wdog <= '0;
          if (cap_d == '0) begin
            cap_q   <= 8'hFF;
            cap_r   <= cap_n;
            cap_err <= 1'b1;
          end
        end
        WAIT: begin
          if (done_ok) begin
            cap_q   <= div_q;
            cap_r   <= div_r;
            cap_err <= 1'b0;
          end else if (tmo_hit) begin
            cap_q   <= '0;
            cap_r   <= '0;
            cap_err <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[owner])
            rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_q   = cap_q;
  assign rsp_r   = cap_r;
  assign rsp_err = cap_err;
  assign div_n   = cap_n;
  assign div_d   = cap_d;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed scenarios plus random traffic. A monitor
// predicts grants with its own round-robin model, queues the expected
// response at each accept, and checks the response when it appears.
module tb_div_arbiter;
  localparam int NREQ = 4;
  localparam int TMO  = 64;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req_valid = '0, req_ready;
  logic [16*NREQ-1:0]  req_n = '0, req_d = '0;
  logic [NREQ-1:0]     rsp_valid, rsp_ready = '0;
  logic [7:0]          rsp_q;
  logic [15:0]         rsp_r;
  logic                rsp_err, div_start, busy;
  logic [15:0]         div_n, div_d;
  logic [7:0]          div_q = '0;
  logic [15:0]         div_r = '0;
  logic                div_done = 1'b0;

  div_arbiter #(.NREQ(NREQ), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_n(req_n), .req_d(req_d), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err), .div_start(div_start),
    .div_n(div_n), .div_d(div_d), .div_q(div_q), .div_r(div_r),
    .div_done(div_done), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Divider model: 8 iteration steps after start; done stays high until the
  // cycle after the next start, so a stale done reaches the first WAIT cycle.
  bit          hang = 0;
  int          dcnt = 0;
  logic        start_d = 1'b0;
  logic [15:0] opn = '0, opd = '0;
  always @(posedge clk) begin
    start_d <= div_start;
    if (div_start) begin
      dcnt <= 8; opn <= div_n; opd <= div_d;
    end else if (dcnt > 1) dcnt <= dcnt - 1;
    else if (dcnt == 1) begin
      dcnt <= 0;
      if (!hang) begin
        div_done <= 1'b1; div_q <= 8'(opn / opd); div_r <= opn % opd;
      end
    end
    if (start_d) div_done <= 1'b0;
  end

  // Reference model and scoreboard.
  typedef struct {
    int owner; logic [15:0] n, d, r; logic [7:0] q; logic err; int acc; int rsp;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int   grant_log[$];
  int   model_rr = 0;
  bit   first_rsp = 1, stalled = 0;
  logic [24:0] held;

  function automatic int pred(logic [NREQ-1:0] v, int rr);
    for (int k = 0; k < NREQ; k++)
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(int i);
    logic [NREQ-1:0] m;
    m = '0;
    if (i >= 0) m[i] = 1'b1;
    return m;
  endfunction

  // Monitor: checks every cycle on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      check("reset_outputs", {rsp_valid, div_start, busy, rsp_q, rsp_r, rsp_err, div_n, div_d}, '0);
      check("reset_req_ready", req_ready, onehot(pred(req_valid, 0)));
      sb.delete(); model_rr = 0; first_rsp = 1; stalled = 0;
    end else if (sb.size() == 0) begin
      int g;
      g = pred(req_valid, model_rr);
      check("req_ready_idle", req_ready, onehot(g));
      check("busy_idle", busy, 0);
      check("div_start_idle", div_start, 0);
      check("rsp_valid_idle", rsp_valid, 0);
      if (g >= 0 && (req_valid & req_ready) != '0) begin
        e.owner = g; e.n = req_n[16*g +: 16]; e.d = req_d[16*g +: 16]; e.acc = cyc;
        if (e.d == 0) begin
          e.q = 8'hFF; e.r = e.n; e.err = 1; e.rsp = cyc + 2;
        end else if (hang) begin
          e.q = 0; e.r = 0; e.err = 1; e.rsp = cyc + 2 + TMO;
        end else begin
          e.q = 8'(e.n / e.d); e.r = e.n % e.d; e.err = 0; e.rsp = cyc + 11;
        end
        sb.push_back(e); grant_log.push_back(g);
      end
    end else begin
      e = sb[0];
      check("req_ready_busy", req_ready, 0);
      check("busy", busy, 1);
      check("div_start", div_start, (cyc == e.acc + 1) && (e.d != 0));
      if (cyc > e.acc && cyc < e.rsp) check("div_operands", {div_n, div_d}, {e.n, e.d});
      if (cyc == e.rsp) check("rsp_on_time", rsp_valid, onehot(e.owner));
      if (rsp_valid != '0) begin
        check("rsp_valid_owner", rsp_valid, onehot(e.owner));
        if (first_rsp) begin check("rsp_latency", cyc, e.rsp); first_rsp = 0; end
        if (stalled) check("rsp_hold", {rsp_q, rsp_r, rsp_err}, held);
        if (rsp_ready[e.owner]) begin
          check("rsp_data", {rsp_q, rsp_r, rsp_err}, {e.q, e.r, e.err});
          void'(sb.pop_front());
          model_rr = (e.owner + 1) % NREQ; first_rsp = 1; stalled = 0;
        end else begin
          stalled = 1; held = {rsp_q, rsp_r, rsp_err};
        end
      end
    end
  end

  // Stimulus helpers.
  logic [NREQ-1:0] acc;
  task automatic step();
    @(negedge clk);
    acc = reset ? '0 : (req_valid & req_ready);
    @(posedge clk); #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic set_ops(int i, logic [15:0] n, logic [15:0] d);
    req_n[16*i +: 16] = n; req_d[16*i +: 16] = d;
  endtask

  task automatic rand_ops(int i);
    set_ops(i, 16'($urandom), ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 400)));
  endtask

  task automatic reset_dut();
    @(posedge clk); #1; reset = 1'b1; req_valid = '0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || req_valid != '0) && n < 400) begin step(); n++; end
    check("drain_done", {sb.size() != 0, req_valid}, '0);
    if (sb.size() != 0 || req_valid != '0) reset_dut();
  endtask

  initial begin
    int ge[5] = '{0, 1, 2, 3, 0};
    int n;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    rsp_ready = '1;

    // single divide
    set_ops(0, 16'd100, 16'd7); req_valid = 4'b0001; drain();

    // contention from a fresh pointer
    reset_dut();
    grant_log.delete();
    for (int i = 0; i < NREQ; i++) rand_ops(i);
    req_valid = 4'b1111; n = 0;
    while (grant_log.size() < 5 && n < 200) begin
      step(); n++;
      for (int i = 0; i < NREQ; i++)
        if (acc[i] && grant_log.size() < 5) begin req_valid[i] = 1'b1; rand_ops(i); end
    end
    req_valid = '0;
    check("grant_count", grant_log.size(), 5);
    for (int k = 0; k < grant_log.size() && k < 5; k++) check("grant_order", grant_log[k], ge[k]);
    drain();

    // divide by zero
    set_ops(2, 16'd55, 16'd0); req_valid = 4'b0100; drain();

    // backpressure on requester 1
    rsp_ready = 4'b1101;
    set_ops(1, 16'd1000, 16'd33); req_valid = 4'b0010;
    n = 0;
    while (!rsp_valid[1] && n < 50) begin step(); n++; end
    check("bp_rsp_seen", rsp_valid[1], 1);
    repeat (20) step();
    rsp_ready = '1; drain();

    // watchdog timeout
    hang = 1;
    set_ops(3, 16'd9, 16'd3); req_valid = 4'b1000; drain();
    hang = 0;

    // reset during WAIT
    set_ops(1, 16'd300, 16'd20); req_valid = 4'b0010; drain();
    set_ops(2, 16'd500, 16'd9); req_valid = 4'b0100;
    n = 0;
    while (!acc[2] && n < 20) begin step(); n++; end
    repeat (3) step();
    check("busy_before_abort", busy, 1);
    reset_dut();
    set_ops(0, 16'd77, 16'd5); set_ops(3, 16'd1234, 16'd11); req_valid = 4'b1001;
    drain();

    // random traffic
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin rand_ops(i); req_valid[i] = 1'b1; end
      for (int i = 0; i < NREQ; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
      step();
    end
    rsp_ready = '1; drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end
endmodule
